// File: rtl/ras_ckpt.sv
// rtl/ras_ckpt.sv - multi-thread checkpointed return address stack
// Per-thread circular stack with an in-order checkpoint FIFO for commit and flush-by-tag recovery.
module ras_ckpt #(
    parameter int WIDTH   = 31,
    parameter int DEPTH   = 16,
    parameter int THREADS = 2,
    parameter int NCKPT   = 8,
    localparam int ADDR   = $clog2(DEPTH),
    localparam int TW     = (THREADS > 1) ? $clog2(THREADS) : 1,
    localparam int CW     = $clog2(NCKPT)
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               op_valid_i,
    input  logic [TW-1:0]      op_thr_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [WIDTH-1:0]   din_i,
    output logic               op_ready_o,
    output logic [CW-1:0]      ckpt_tag_o,
    output logic [WIDTH-1:0]   dout_o,
    output logic               valid_o,
    input  logic               commit_i,
    input  logic [TW-1:0]      commit_thr_i,
    input  logic               flush_i,
    input  logic [TW-1:0]      flush_thr_i,
    input  logic [CW-1:0]      flush_tag_i,
    output logic [THREADS-1:0] ovf_o
);

    localparam logic [ADDR:0] FULL_CNT = (ADDR+1)'(DEPTH);
    localparam logic [CW:0]   FULL_CK  = (CW+1)'(NCKPT);

    logic [ADDR-1:0]  tosp    [THREADS];
    logic [ADDR:0]    count   [THREADS];
    logic [WIDTH-1:0] mem     [THREADS][DEPTH];
    logic [CW-1:0]    head    [THREADS];
    logic [CW-1:0]    tail    [THREADS];
    logic [CW:0]      used    [THREADS];
    logic [ADDR-1:0]  ck_tosp [THREADS][NCKPT];
    logic [ADDR:0]    ck_count[THREADS][NCKPT];
    logic [WIDTH-1:0] ck_data [THREADS][NCKPT];

    logic [THREADS-1:0] acc;
    logic [THREADS-1:0] cmt;
    logic [THREADS-1:0] flsh;
    logic [CW-1:0]      fdist [THREADS];

    // Flush legality is judged against the pre-commit tail/used; a legal flush squashes same-thread ops.
    always_comb begin
        for (int t = 0; t < THREADS; t++) begin
            cmt[t]   = commit_i && (commit_thr_i == TW'(t)) && (used[t] != '0);
            fdist[t] = flush_tag_i - tail[t];
            flsh[t]  = flush_i && (flush_thr_i == TW'(t)) && ({1'b0, fdist[t]} < used[t]);
            acc[t]   = op_valid_i && (op_thr_i == TW'(t)) && (push_i || pop_i)
                       && (used[t] != FULL_CK) && !flsh[t];
        end
    end

    always_comb begin
        op_ready_o = 1'b0;
        ckpt_tag_o = '0;
        dout_o     = '0;
        valid_o    = 1'b0;
        for (int t = 0; t < THREADS; t++) begin
            if (op_thr_i == TW'(t)) begin
                op_ready_o = (used[t] != FULL_CK);
                ckpt_tag_o = head[t];
                dout_o     = mem[t][tosp[t]];
                valid_o    = (count[t] != '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            ovf_o <= '0;
            for (int t = 0; t < THREADS; t++) begin
                tosp[t]  <= '0;
                count[t] <= '0;
                head[t]  <= '0;
                tail[t]  <= '0;
                used[t]  <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    mem[t][d] <= '0;
                end
                for (int c = 0; c < NCKPT; c++) begin
                    ck_tosp[t][c]  <= '0;
                    ck_count[t][c] <= '0;
                    ck_data[t][c]  <= '0;
                end
            end
        end else begin
            for (int t = 0; t < THREADS; t++) begin
                tail[t] <= tail[t] + CW'(cmt[t]);
                if (flsh[t]) begin
                    tosp[t]  <= ck_tosp[t][flush_tag_i];
                    count[t] <= ck_count[t][flush_tag_i];
                    mem[t][ck_tosp[t][flush_tag_i]] <= ck_data[t][flush_tag_i];
                    head[t]  <= flush_tag_i;
                    // A same-cycle commit removes the oldest survivor as well.
                    if (cmt[t]) begin
                        used[t] <= (fdist[t] == '0) ? '0 : {1'b0, fdist[t]} - (CW+1)'(1);
                    end else begin
                        used[t] <= {1'b0, fdist[t]};
                    end
                end else begin
                    used[t] <= used[t] + (CW+1)'(acc[t]) - (CW+1)'(cmt[t]);
                    if (acc[t]) begin
                        ck_tosp[t][head[t]]  <= tosp[t];
                        ck_count[t][head[t]] <= count[t];
                        ck_data[t][head[t]]  <= mem[t][tosp[t]];
                        head[t]              <= head[t] + CW'(1);
                        if (push_i && pop_i) begin
                            mem[t][tosp[t]] <= din_i;
                        end else if (push_i) begin
                            tosp[t]                     <= tosp[t] + ADDR'(1);
                            mem[t][tosp[t] + ADDR'(1)]  <= din_i;
                            if (count[t] == FULL_CNT) begin
                                ovf_o[t] <= 1'b1;
                            end else begin
                                count[t] <= count[t] + (ADDR+1)'(1);
                            end
                        end else if (count[t] != '0) begin
                            tosp[t]  <= tosp[t] - ADDR'(1);
                            count[t] <= count[t] - (ADDR+1)'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ras_ckpt.sv
// tb/tb_ras_ckpt.sv - self-checking bench for ras_ckpt
// Vectors carry stimulus plus the outputs expected before the edge that applies them.
module tb_ras_ckpt;

    localparam int WIDTH = 31;
    localparam int DEPTH = 4;
    localparam int THREADS = 2;
    localparam int NCKPT = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             op_valid = 1'b0;
    logic [0:0]       op_thr = '0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             op_ready;
    logic [2:0]       ckpt_tag;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             commit = 1'b0;
    logic [0:0]       commit_thr = '0;
    logic             flush = 1'b0;
    logic [0:0]       flush_thr = '0;
    logic [2:0]       flush_tag = '0;
    logic [1:0]       ovf;

    ras_ckpt #(.WIDTH(WIDTH), .DEPTH(DEPTH), .THREADS(THREADS), .NCKPT(NCKPT)) dut (
        .clk(clk), .rst_i(rst),
        .op_valid_i(op_valid), .op_thr_i(op_thr), .push_i(push), .pop_i(pop), .din_i(din),
        .op_ready_o(op_ready), .ckpt_tag_o(ckpt_tag), .dout_o(dout), .valid_o(valid),
        .commit_i(commit), .commit_thr_i(commit_thr),
        .flush_i(flush), .flush_thr_i(flush_thr), .flush_tag_i(flush_tag),
        .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       ov;
        int       thr;
        bit       ps;
        bit       pp;
        int       din;
        bit       cm;
        int       cthr;
        bit       fl;
        int       fthr;
        int       ftag;
        bit       rdy;
        int       tag;
        int       dout;
        bit       vld;
        bit [1:0] ovf;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int checks = 0;
    int failures = 0;

    function automatic vec_t mk(input bit ov, input int thr, input bit ps, input bit pp,
                                input int d, input bit cm, input int cthr, input bit fl,
                                input int fthr, input int ftag, input bit rdy, input int tag,
                                input int dexp, input bit vld, input bit [1:0] ov_exp);
        vec_t v;
        v.ov = ov; v.thr = thr; v.ps = ps; v.pp = pp; v.din = d;
        v.cm = cm; v.cthr = cthr; v.fl = fl; v.fthr = fthr; v.ftag = ftag;
        v.rdy = rdy; v.tag = tag; v.dout = dexp; v.vld = vld; v.ovf = ov_exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        vec_t e;
        @(posedge clk);
        #1;
        op_valid = v.ov; op_thr = v.thr[0:0]; push = v.ps; pop = v.pp; din = v.din[WIDTH-1:0];
        commit = v.cm; commit_thr = v.cthr[0:0];
        flush = v.fl; flush_thr = v.fthr[0:0]; flush_tag = v.ftag[2:0];
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        check({name, ".op_ready"}, 32'(op_ready), 32'(e.rdy));
        check({name, ".ckpt_tag"}, 32'(ckpt_tag), 32'(e.tag));
        check({name, ".dout"}, 32'(dout), 32'(e.dout));
        check({name, ".valid"}, 32'(valid), 32'(e.vld));
        check({name, ".ovf"}, 32'(ovf), 32'(e.ovf));
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("%s[%0d]", name, i));
        end
        tbl.delete();
    endtask

    task automatic idle_inputs(input int thr);
        op_valid = 0; push = 0; pop = 0; commit = 0; flush = 0; op_thr = thr[0:0];
    endtask

    // Reset asserted between edges must clear outputs without waiting for a clock.
    task automatic async_reset(input int thr);
        idle_inputs(thr);
        #2;
        rst = 1'b1;
        #1;
        check("rst.op_ready", 32'(op_ready), 32'd1);
        check("rst.ckpt_tag", 32'(ckpt_tag), 32'd0);
        check("rst.dout", 32'(dout), 32'd0);
        check("rst.valid", 32'(valid), 32'd0);
        check("rst.ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #12 rst = 1'b0;

        // push/pop on thread 0, then overflow wrap on thread 1 with per-op commits
        tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0, 1,0,0,0,2'b00));
        tbl.push_back(mk(1,0,1,0,'h100, 0,0,0,0,0, 1,0,0,0,2'b00));
        tbl.push_back(mk(1,0,1,0,'h200, 0,0,0,0,0, 1,1,'h100,1,2'b00));
        tbl.push_back(mk(1,0,0,1,0,     0,0,0,0,0, 1,2,'h200,1,2'b00));
        tbl.push_back(mk(1,0,0,1,0,     0,0,0,0,0, 1,3,'h100,1,2'b00));
        tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0, 1,4,0,0,2'b00));
        tbl.push_back(mk(1,1,1,0,1,     1,0,0,0,0, 1,0,0,0,2'b00));
        tbl.push_back(mk(1,1,1,0,2,     1,1,0,0,0, 1,1,1,1,2'b00));
        tbl.push_back(mk(1,1,1,0,3,     1,1,0,0,0, 1,2,2,1,2'b00));
        tbl.push_back(mk(1,1,1,0,4,     1,1,0,0,0, 1,3,3,1,2'b00));
        tbl.push_back(mk(1,1,1,0,5,     1,1,0,0,0, 1,4,4,1,2'b00));
        tbl.push_back(mk(1,1,0,1,0,     1,1,0,0,0, 1,5,5,1,2'b10));
        tbl.push_back(mk(1,1,0,1,0,     1,1,0,0,0, 1,6,4,1,2'b10));
        tbl.push_back(mk(1,1,0,1,0,     1,1,0,0,0, 1,7,3,1,2'b10));
        tbl.push_back(mk(1,1,0,1,0,     1,1,0,0,0, 1,0,2,1,2'b10));
        tbl.push_back(mk(0,1,0,0,0,     1,1,0,0,0, 1,1,5,0,2'b10));
        run_table("basic");

        async_reset(1);

        // flush repair, cross-thread flush, commit+flush of the same tag, illegal flush
        tbl.push_back(mk(1,0,1,0,'hA,   0,0,0,0,0, 1,0,0,0,2'b00));
        tbl.push_back(mk(1,0,0,1,0,     0,0,0,0,0, 1,1,'hA,1,2'b00));
        tbl.push_back(mk(1,0,1,0,'hB,   0,0,0,0,0, 1,2,0,0,2'b00));
        tbl.push_back(mk(0,0,0,0,0,     0,0,1,0,1, 1,3,'hB,1,2'b00));
        tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0, 1,1,'hA,1,2'b00));
        tbl.push_back(mk(1,0,0,1,0,     0,0,0,0,0, 1,1,'hA,1,2'b00));
        tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0, 1,2,0,0,2'b00));
        tbl.push_back(mk(1,1,1,0,'h77,  0,0,0,0,0, 1,0,0,0,2'b00));
        tbl.push_back(mk(1,1,1,0,'h88,  0,0,0,0,0, 1,1,'h77,1,2'b00));
        tbl.push_back(mk(1,0,1,0,'h99,  0,0,1,1,1, 1,2,0,0,2'b00));
        tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0, 1,3,'h99,1,2'b00));
        tbl.push_back(mk(0,1,0,0,0,     0,0,0,0,0, 1,1,'h77,1,2'b00));
        tbl.push_back(mk(1,0,1,0,'h55,  1,0,1,0,0, 1,3,'h99,1,2'b00));
        tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0, 1,0,0,0,2'b00));
        tbl.push_back(mk(1,0,1,0,'h66,  0,0,0,0,0, 1,0,0,0,2'b00));
        tbl.push_back(mk(0,0,0,0,0,     0,0,1,0,0, 1,1,'h66,1,2'b00));
        tbl.push_back(mk(0,0,0,0,0,     0,0,0,0,0, 1,1,'h66,1,2'b00));
        run_table("flush");

        async_reset(0);

        // checkpoint queue full: eight uncommitted pushes, a refused ninth, then one commit
        for (int k = 0; k < 8; k++) begin
            apply(mk(1,0,1,0,'h10+k, 0,0,0,0,0, 1,k, (k == 0) ? 0 : 'h10+k-1, k > 0,
                     (k >= 5) ? 2'b01 : 2'b00), $sformatf("full.push%0d", k));
        end
        apply(mk(1,0,1,0,'hFF, 0,0,0,0,0, 0,0,'h17,1,2'b01), "full.ninth");
        apply(mk(0,0,0,0,0,    1,0,0,0,0, 0,0,'h17,1,2'b01), "full.commit");
        apply(mk(0,0,0,0,0,    0,0,0,0,0, 1,0,'h17,1,2'b01), "full.after");

        // mid-cycle reset with populated state on the observed thread
        @(posedge clk);
        #1;
        idle_inputs(0);
        #1;
        check("pre_rst.dout", 32'(dout), 32'h17);
        check("pre_rst.ovf", 32'(ovf), 32'h1);
        async_reset(0);
        apply(mk(0,0,0,0,0, 0,0,0,0,0, 1,0,0,0,2'b00), "post_rst");

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ras_ckpt.md
# ras_ckpt

Multi-thread, checkpointed return address stack, the parametrised successor to the two-stage speculative RAS. Each of `THREADS` hardware contexts owns a circular stack of `DEPTH` return addresses and an in-order checkpoint queue of `NCKPT` entries. Every accepted call/return allocates a checkpoint tag. Commit retires tags oldest-first. Flush by tag restores the pointer, the occupancy count and the overwritten top-of-stack entry. The block sits between fetch (ops, prediction read) and the branch resolution unit (commit/flush).

## Interface
Parameters:
- `WIDTH`, 31: return address width.
- `DEPTH`, 16: entries per thread stack; must be a power of two, at least 2.
- `THREADS`, 2: number of contexts; at least 1.
- `NCKPT`, 8: checkpoints per thread; must be a power of two, at least 2.
- Derived localparams: `ADDR = $clog2(DEPTH)`, `TW = max(1, $clog2(THREADS))`, `CW = $clog2(NCKPT)`.

Ports:
- `clk` input 1: single clock; all state is updated on the rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `op_valid_i` input 1: a call/return op is presented this cycle.
- `op_thr_i` input TW: thread targeted by the op, and the thread whose top-of-stack is read.
- `push_i` input 1: call; push `din_i`.
- `pop_i` input 1: return; pop. `push_i` and `pop_i` together mean replace the top entry.
- `din_i` input WIDTH: return address to push.
- `op_ready_o` output 1: thread `op_thr_i` has a free checkpoint.
- `ckpt_tag_o` output CW: tag allocated to the op if it is accepted this cycle.
- `dout_o` output WIDTH: top of stack of `op_thr_i`.
- `valid_o` output 1: count of `op_thr_i` is nonzero.
- `commit_i` input 1: retire the oldest checkpoint of `commit_thr_i`.
- `commit_thr_i` input TW: thread to commit.
- `flush_i` input 1: mispredict recovery.
- `flush_thr_i` input TW: thread to flush.
- `flush_tag_i` input CW: tag of the oldest op to be squashed.
- `ovf_o` output THREADS: per-thread sticky flag, set when a push occurs while count equals `DEPTH`.

## Operation
- Per-thread state:
  - `tosp` (ADDR bits, wraps modulo DEPTH).
  - `count` (ADDR+1 bits, 0..DEPTH).
  - Storage `mem[DEPTH]` (flops).
  - Checkpoint FIFO with `head`, `tail` and `used` (0..NCKPT).
  - Each slot holds {tosp, count, mem[tosp]} as captured before its op.
- Accept condition: `op_valid_i && (push_i || pop_i) && op_ready_o`, where `op_ready_o = used < NCKPT`.
  - On accept, slot `head` is written and `ckpt_tag_o = head`; then head increments and used increments.
  - `op_valid_i` with neither push nor pop is a no-op and allocates nothing.
- Push: `tosp := tosp+1`, `mem[tosp+1] := din_i`, `count := min(count+1, DEPTH)`.
  - At full, the oldest entry is overwritten and `ovf_o[thr]` is set.
- Pop: if `count > 0`, then `tosp := tosp-1` and `count := count-1`.
  - If `count == 0`, there is no state change, but the checkpoint is still allocated.
- Push+pop: `mem[tosp] := din_i`; tosp and count are unchanged.
- Commit: if `used > 0`, then tail increments and used decrements. Otherwise it is ignored.
- Flush tag t is legal iff `(t - tail) mod NCKPT < used`. An illegal tag is ignored entirely.
  - Legal flush restores tosp and count from slot t.
  - It writes the saved data back to `mem[saved tosp]`.
  - It sets `head := t` and `used := (t - tail) mod NCKPT`.
- Priority across threads: independent; different threads may op, commit and flush in the same cycle.
- Priority within one thread, same cycle:
  - Commit is applied first, to tail and used.
  - Flush is then applied, with legality evaluated against the pre-commit tail and used.
  - The op is dropped when flush targets the same thread. `op_ready_o` is still driven, but no tag is allocated.
  - Commit of tag t together with flush of tag t: restore from slot t; used becomes 0.
- `dout_o = mem[op_thr_i][tosp]`. This is combinational from registered state and carries no bypass of this cycle's op.
- Reset: all tosp, count, head, tail and used are 0; `ovf_o` is 0; mem is cleared to 0. `ovf_o` is cleared only by reset.

## Timing
- Op, commit and flush take effect on the next rising edge. `dout_o` and `valid_o` reflect the new state in the following cycle.
- `op_ready_o` and `ckpt_tag_o` are combinational from state and `op_thr_i`, and valid in the same cycle as the op.
- Outputs during and immediately after reset:
  - `valid_o = 0` and `dout_o = 0`.
  - `op_ready_o = 1` and `ckpt_tag_o = 0`.
  - `ovf_o = 0`.
- Reset asserted mid-sequence discards all stack and checkpoint state asynchronously. There is no partial-restore behaviour.
- No multi-cycle operations; throughput is one op per cycle.

## Test plan
- **Reset, push and pop:**
  - Stimulus: reset, then push 0x100 on thread 0, then push 0x200.
  - Required: `dout_o = 0x200`, tags 0 and 1 returned.
  - Then pop: `dout_o = 0x100`, `valid_o = 1`. Pop again: `valid_o = 0`.
- **Overflow wrap:**
  - Stimulus: DEPTH=4; push 1..5 on thread 1, committing each op.
  - Required: count = 4, `ovf_o[1] = 1`, `dout_o = 5`.
  - Then 4 pops return 5, 4, 3, 2, and `valid_o = 0`.
- **Flush repair:**
  - Stimulus: push A (tag 0); pop (tag 1); push B (tag 2, overwrites A's slot); flush tag 1.
  - Required: `dout_o = A`, count = 1, `used = 1`, next tag = 1.
- **Checkpoint full:**
  - Stimulus: NCKPT=8; 8 uncommitted pushes.
  - Required: `op_ready_o = 0`; a 9th push leaves state unchanged.
  - Then commit: `op_ready_o = 1` and the next tag = 0.
- **Simultaneous events:**
  - Stimulus, same cycle on thread 0: commit of the oldest tag t, flush of tag t, and a push.
  - Required: push dropped, state restored from slot t, `used = 0`.
  - Stimulus: flush of an illegal tag. Required: no state change.
- **Thread isolation and async reset:**
  - Stimulus: ops on thread 0 and a flush on thread 1 in the same cycle.
  - Required: both take effect; thread 0's state is unaffected by thread 1's flush.
  - Stimulus: assert `rst_i` between edges. Required: outputs return to reset values immediately.
